bram_fifo_ctrl: RTL and testbench

//  Streaming FIFO controller in front of the 16K x 32 true-dual-port block RAM.

---
 rtl/bram_fifo_ctrl.sv | 122 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// Streaming FIFO controller around a true-dual-port BRAM: port A commits the write stream,
// port B reads ahead into a 2-entry output register queue that feeds the read stream.
module bram_fifo_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [ADDR_W+1:0] level,
    output logic              we_a,
    output logic [ADDR_W-1:0] addr_a,
    output logic [DATA_W-1:0] din_a,
    output logic              we_b,
    output logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] dout_b
);

    localparam int unsigned DEPTH = 32'd1 << ADDR_W;
    localparam int unsigned PTR_W = ADDR_W + 1;
    localparam int unsigned LVL_W = ADDR_W + 2;

    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [PTR_W-1:0]  w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic [PTR_W-1:0]  w_bram_cnt, w_bram_cnt_nxt;
    logic              r_inflight, w_inflight_nxt;
    logic [1:0]        r_buf_cnt, w_buf_cnt_nxt;
    logic [DATA_W-1:0] r_buf0, r_buf1, w_buf0_nxt, w_buf1_nxt;
    logic [LVL_W-1:0]  r_level, w_level_nxt;
    logic [ADDR_W-1:0] r_addr_b;
    logic              w_full, w_push, w_issue, w_pop, w_cap;

    // Wrap-bit pointers: the difference distinguishes full from empty.
    assign w_bram_cnt = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_bram_cnt == PTR_W'(DEPTH));
    assign w_push     = s_valid && !w_full && !clr && rst_n;
    assign w_issue    = (w_bram_cnt != '0) && ((r_buf_cnt + {1'b0, r_inflight}) < 2'd2) && !clr;
    assign w_pop      = (r_buf_cnt != 2'd0) && m_ready;
    assign w_cap      = r_inflight;

    assign s_ready = !w_full;
    assign we_a    = w_push;
    assign addr_a  = r_wr_ptr[ADDR_W-1:0];
    assign din_a   = s_data;
    assign we_b    = 1'b0;
    assign addr_b  = w_issue ? r_rd_ptr[ADDR_W-1:0] : r_addr_b;
    assign m_valid = (r_buf_cnt != 2'd0);
    assign m_data  = r_buf0;
    assign level   = r_level;

    // Next-state: pointers, read-in-flight flag, output queue and occupancy.
    always_comb begin
        w_wr_ptr_nxt   = r_wr_ptr;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_inflight_nxt = w_issue;
        w_buf0_nxt     = r_buf0;
        w_buf1_nxt     = r_buf1;
        w_buf_cnt_nxt  = r_buf_cnt;
        if (clr) begin
            w_wr_ptr_nxt   = '0;
            w_rd_ptr_nxt   = '0;
            w_inflight_nxt = 1'b0;
            w_buf0_nxt     = '0;
            w_buf1_nxt     = '0;
            w_buf_cnt_nxt  = 2'd0;
        end else begin
            if (w_push)  w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            if (w_issue) w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            case ({w_pop, w_cap})
                2'b11: begin
                    if (r_buf_cnt == 2'd1) begin
                        w_buf0_nxt = dout_b;
                    end else begin
                        w_buf0_nxt = r_buf1;
                        w_buf1_nxt = dout_b;
                    end
                end
                2'b10: begin
                    w_buf0_nxt    = r_buf1;
                    w_buf_cnt_nxt = r_buf_cnt - 2'd1;
                end
                2'b01: begin
                    if (r_buf_cnt == 2'd0) w_buf0_nxt = dout_b;
                    else                   w_buf1_nxt = dout_b;
                    w_buf_cnt_nxt = r_buf_cnt + 2'd1;
                end
                default: ;
            endcase
        end
        w_bram_cnt_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
        w_level_nxt    = LVL_W'(w_bram_cnt_nxt) + LVL_W'(w_inflight_nxt) + LVL_W'(w_buf_cnt_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_buf0     <= '0;
            r_buf1     <= '0;
            r_buf_cnt  <= 2'd0;
            r_level    <= '0;
            r_addr_b   <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_inflight <= w_inflight_nxt;
            r_buf0     <= w_buf0_nxt;
            r_buf1     <= w_buf1_nxt;
            r_buf_cnt  <= w_buf_cnt_nxt;
            r_level    <= w_level_nxt;
            r_addr_b   <= addr_b;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a 16-word BRAM model (registered port-B read).
module tb_bram_fifo_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DEPTH  = 32'd1 << ADDR_W;

    logic              clk, rst_n, clr, s_valid, s_ready, m_valid, m_ready, we_a, we_b;
    logic [DATA_W-1:0] s_data, m_data, din_a, dout_b;
    logic [ADDR_W+1:0] level;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [DATA_W-1:0] mem [DEPTH];

    int errors   = 0;
    int checks   = 0;
    int web_hits = 0;

    bram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level),
        .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
        .we_b(we_b), .addr_b(addr_b), .dout_b(dout_b)
    );

    always #5 clk = ~clk;

    // Same-address write/read returns a corrupted word so a collision shows up as bad data.
    always @(posedge clk) begin
        if (we_a) mem[addr_a] <= din_a;
        dout_b <= (we_a && addr_a == addr_b) ? ~din_a : mem[addr_b];
        if (we_b !== 1'b0) web_hits <= web_hits + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        int acc, wa, e, sent, rcvd;
        clk = 1'b0; rst_n = 1'b0; clr = 1'b0;
        s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        #2;
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_data",  64'(m_data),  64'd0);
        chk("rst_level",   64'(level),   64'd0);
        chk("rst_we_a",    64'(we_a),    64'd0);
        chk("rst_we_b",    64'(we_b),    64'd0);
        chk("rst_addr_a",  64'(addr_a),  64'd0);
        chk("rst_addr_b",  64'(addr_b),  64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        nxt(); nxt();
        rst_n = 1'b1;
        nxt();

        // Single word: push at cycle 0, visible at cycle 3
        s_valid = 1'b1; s_data = 32'hDEADBEEF; m_ready = 1'b1; settle();
        chk("t1_we_a",  64'(we_a),  64'd1);
        chk("t1_din_a", 64'(din_a), 64'hDEADBEEF);
        nxt(); s_valid = 1'b0; s_data = '0; settle();
        chk("t1_level_c1",  64'(level),   64'd1);
        chk("t1_mvalid_c1", 64'(m_valid), 64'd0);
        nxt(); settle();
        chk("t1_level_c2",  64'(level),   64'd1);
        chk("t1_mvalid_c2", 64'(m_valid), 64'd0);
        nxt(); settle();
        chk("t1_mvalid_c3", 64'(m_valid), 64'd1);
        chk("t1_mdata_c3",  64'(m_data),  64'hDEADBEEF);
        chk("t1_level_c3",  64'(level),   64'd1);
        nxt(); settle();
        chk("t1_level_c4",  64'(level),   64'd0);
        chk("t1_mvalid_c4", 64'(m_valid), 64'd0);
        nxt();

        // Fill with no consumer: DEPTH+2 words accepted
        m_ready = 1'b0; acc = 0; wa = 0;
        for (int i = 0; i < 24; i++) begin
            s_valid = 1'b1; s_data = 32'(acc); settle();
            if (we_a) wa++;
            if (s_valid && s_ready) acc++;
            nxt();
        end
        s_valid = 1'b0; settle();
        chk("t2_accepted", 64'(acc),     64'd18);
        chk("t2_we_a_cnt", 64'(wa),      64'd18);
        chk("t2_level",    64'(level),   64'd18);
        chk("t2_s_ready",  64'(s_ready), 64'd0);
        chk("t2_head",     64'(m_data),  64'd0);
        nxt();

        // Full + pop: no write now, s_ready returns two cycles later
        s_valid = 1'b1; s_data = 32'h100; m_ready = 1'b1; settle();
        chk("t4_we_a_full",  64'(we_a),    64'd0);
        chk("t4_sready_c0",  64'(s_ready), 64'd0);
        chk("t4_head_c0",    64'(m_data),  64'd0);
        nxt(); s_valid = 1'b0; m_ready = 1'b0; settle();
        chk("t4_sready_c1",  64'(s_ready), 64'd0);
        chk("t4_level_c1",   64'(level),   64'd17);
        chk("t4_head_c1",    64'(m_data),  64'd1);
        nxt(); settle();
        chk("t4_sready_c2",  64'(s_ready), 64'd1);
        chk("t4_level_c2",   64'(level),   64'd17);
        s_valid = 1'b1; s_data = 32'h100; settle();
        chk("t4_we_a_c2",    64'(we_a),    64'd1);
        nxt(); s_valid = 1'b0; m_ready = 1'b1;
        e = 0;
        for (int c = 0; c < 200 && e < 18; c++) begin
            settle();
            if (m_valid && m_ready) begin
                chk("t4_drain", 64'(m_data), (e < 17) ? 64'(e + 1) : 64'h100);
                e++;
            end
            nxt();
        end
        chk("t4_drain_count", 64'(e), 64'd18);
        settle();
        chk("t4_level_empty", 64'(level), 64'd0);
        nxt();

        // clr with a read in flight
        m_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_data = 32'hC0 + 32'(k); settle();
            nxt();
        end
        s_valid = 1'b1; s_data = 32'hBAD; clr = 1'b1; settle();
        chk("t5_we_a_clr", 64'(we_a), 64'd0);
        nxt(); clr = 1'b0; s_valid = 1'b0; settle();
        chk("t5_mvalid_after", 64'(m_valid), 64'd0);
        chk("t5_level_after",  64'(level),   64'd0);
        s_valid = 1'b1; s_data = 32'h1234; m_ready = 1'b1; settle();
        chk("t5_we_a_push", 64'(we_a), 64'd1);
        nxt(); s_valid = 1'b0; settle();
        chk("t5_mvalid_p1", 64'(m_valid), 64'd0);
        nxt(); settle();
        chk("t5_mvalid_p2", 64'(m_valid), 64'd0);
        nxt(); settle();
        chk("t5_mvalid_p3", 64'(m_valid), 64'd1);
        chk("t5_mdata_p3",  64'(m_data),  64'h1234);
        nxt(); settle();
        chk("t5_level_end", 64'(level), 64'd0);
        nxt();

        // Random backpressure, in-order delivery
        sent = 0; rcvd = 0;
        for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
            s_valid = (sent < 1000) && ($urandom_range(3) != 0);
            s_data  = 32'h1000_0000 + 32'(sent);
            m_ready = ($urandom_range(2) != 0);
            settle();
            if (s_valid && s_ready) sent++;
            if (m_valid && m_ready) begin
                chk("t3_data", 64'(m_data), 64'(32'h1000_0000 + 32'(rcvd)));
                rcvd++;
            end
            nxt();
        end
        s_valid = 1'b0; m_ready = 1'b0; settle();
        chk("t3_rcvd",     64'(rcvd),     64'd1000);
        chk("t3_level",    64'(level),    64'd0);
        chk("t3_we_b_hit", 64'(web_hits), 64'd0);
        nxt();

        // Async reset mid-stream at level 10
        for (int k = 0; k < 10; k++) begin
            s_valid = 1'b1; s_data = 32'h600 + 32'(k); settle();
            nxt();
        end
        s_valid = 1'b0; settle();
        chk("t6_level_pre", 64'(level), 64'd10);
        s_valid = 1'b1; m_ready = 1'b1; rst_n = 1'b0; settle();
        chk("t6_m_valid", 64'(m_valid), 64'd0);
        chk("t6_m_data",  64'(m_data),  64'd0);
        chk("t6_level",   64'(level),   64'd0);
        chk("t6_we_a",    64'(we_a),    64'd0);
        chk("t6_s_ready", 64'(s_ready), 64'd1);
        chk("t6_addr_a",  64'(addr_a),  64'd0);
        chk("t6_addr_b",  64'(addr_b),  64'd0);
        nxt(); rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        nxt();
        s_valid = 1'b1; s_data = 32'hA5A5A5A5; m_ready = 1'b1; settle();
        chk("t6_we_a_push", 64'(we_a), 64'd1);
        nxt(); s_valid = 1'b0; settle();
        chk("t6_mvalid_p1", 64'(m_valid), 64'd0);
        nxt(); settle();
        chk("t6_mvalid_p2", 64'(m_valid), 64'd0);
        nxt(); settle();
        chk("t6_mvalid_p3", 64'(m_valid), 64'd1);
        chk("t6_mdata_p3",  64'(m_data),  64'hA5A5A5A5);
        nxt(); settle();
        chk("t6_level_end", 64'(level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
